// File: rtl/uart_pkg.sv
// Shared constants for the framed UART receiver: parity modes, FSM encoding,
// status-field positions inside a FIFO entry, and the 3-sample majority vote.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // FIFO entry layout: {data, parity_err, frame_err, break}
  localparam int ST_BRK = 0;
  localparam int ST_FRM = 1;
  localparam int ST_PAR = 2;
  localparam int ST_W   = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } rx_state_e;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received words plus status. Pointers carry one
// extra wrap bit so full and empty differ only in the MSB.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             ser_ck,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp_q, wp_d;
  logic [AW:0]      rp_q, rp_d;
  logic             do_push, do_pop;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign head  = mem[rp_q[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wp_d    = do_push ? wp_q + 1'b1 : wp_q;
    rp_d    = do_pop  ? rp_q + 1'b1 : rp_q;
  end

  always_ff @(posedge ser_ck) begin
    if (do_push) mem[wp_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge ser_ck or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

endmodule

// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver: majority-voted bit sampling, configurable
// framing, per-word error status and a small receive FIFO.
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int SRC_CLOCK  = 0,
  parameter int BAUDS      = 0,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 ser_ck,
  input  logic                 rst_n,
  input  logic                 serin,
  input  logic                 rd_data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 available,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int TICKS = (BAUDS > 0) ? SRC_CLOCK / BAUDS : 8;
  localparam int HALF  = TICKS / 2;
  localparam int CW    = $clog2(TICKS) + 1;
  localparam int EW    = DATA_BITS + ST_W;

  rx_state_e            state_q, state_d;
  logic                 s1_q, s2_q;
  logic [2:0]           tap_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 pbit_q, pbit_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;
  logic                 overrun_q, overrun_d;

  logic          vote, fall, at_half, at_tick;
  logic          frame_now, brk_now;
  logic          push, pop, full, empty;
  logic [EW-1:0] push_word, head;

  assign vote    = maj3(tap_q);
  assign fall    = tap_q[0] & ~s2_q;
  assign at_half = (cnt_q == CW'(HALF));
  assign at_tick = (cnt_q == CW'(TICKS - 1));

  always_ff @(posedge ser_ck or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      tap_q <= 3'b111;
    end else begin
      s1_q  <= serin;
      s2_q  <= s1_q;
      tap_q <= {tap_q[1:0], s2_q};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    pbit_d    = pbit_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    brk_d     = brk_q;
    frame_now = ferr_q;
    brk_now   = brk_q;
    push      = 1'b0;
    push_word = '0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = S_START;
          bit_d   = '0;
          pbit_d  = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          brk_d   = 1'b0;
        end
      end
      S_START: begin
        if (at_half) begin
          cnt_d   = '0;
          state_d = vote ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (at_tick) begin
          cnt_d   = '0;
          shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (at_tick) begin
          cnt_d   = '0;
          pbit_d  = vote;
          perr_d  = ((^shreg_q) ^ vote) != (PARITY == PAR_ODD);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (at_tick) begin
          cnt_d     = '0;
          frame_now = ferr_q | ~vote;
          // Break is judged on the first stop bit only.
          if (bit_q == 4'd0) brk_now = ~vote & ~pbit_q & (shreg_q == '0);
          if (bit_q == 4'(STOP_BITS - 1)) begin
            push                    = 1'b1;
            push_word[EW-1:ST_W]    = shreg_q;
            push_word[ST_PAR]       = perr_q;
            push_word[ST_FRM]       = frame_now;
            push_word[ST_BRK]       = brk_now;
            state_d                 = vote ? S_IDLE : S_WAIT_IDLE;
          end else begin
            bit_d  = bit_q + 1'b1;
            ferr_d = frame_now;
            brk_d  = brk_now;
          end
        end
      end
      S_WAIT_IDLE: begin
        cnt_d = '0;
        if (s2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ser_ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      pbit_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      pbit_q  <= pbit_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .ser_ck (ser_ck),
    .rst_n  (rst_n),
    .push   (push),
    .wdata  (push_word),
    .pop    (pop),
    .head   (head),
    .full   (full),
    .empty  (empty)
  );

  assign pop = rd_data & ~empty;

  // A same-cycle pop makes room, so only a push with no pop overruns.
  always_comb begin
    overrun_d = overrun_q;
    if (pop)              overrun_d = 1'b0;
    else if (push & full) overrun_d = 1'b1;
  end

  always_ff @(posedge ser_ck or negedge rst_n) begin
    if (!rst_n) overrun_q <= 1'b0;
    else        overrun_q <= overrun_d;
  end

  assign available  = ~empty;
  assign rx_data    = empty ? '0 : head[EW-1:ST_W];
  assign parity_err = ~empty & head[ST_PAR];
  assign frame_err  = ~empty & head[ST_FRM];
  assign break_det  = ~empty & head[ST_BRK];
  assign overrun    = overrun_q;

endmodule
